// File: rtl/q2a03_joypad.sv
// rtl/q2a03_joypad.sv - NES-style joypad ports at $4016/$4017 with serial button shift registers
// Reads shift out one button per completed bus cycle; the strobe bit holds both pads in parallel load.
module q2a03_joypad #(
    parameter logic [15:0] P_base     = 16'h4016,
    parameter logic [2:0]  P_open_bus = 3'b010
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic        G_phy2,
    input  logic [15:0] G_addr,
    input  logic        G_rdwr,
    input  logic [7:0]  G_wr_data,
    output logic [7:0]  G_rd_data,
    output logic        G_rd_sel,
    input  logic [7:0]  P_pad1,
    input  logic [7:0]  P_pad2,
    output logic [2:0]  P_out
);

    localparam logic [15:0] P_base2 = P_base + 16'd1;

    logic       phy2_q;
    logic       strobe_q, strobe_d;
    logic [7:0] sr1_q, sr1_d;
    logic [7:0] sr2_q, sr2_d;
    logic [2:0] pout_q, pout_d;

    logic access_end;
    logic sel1, sel2;
    logic unused_wr_bits;

    assign access_end     = phy2_q & ~G_phy2;
    assign sel1           = (G_addr == P_base);
    assign sel2           = (G_addr == P_base2);
    assign unused_wr_bits = ^G_wr_data[7:3];

    assign G_rd_sel = G_rdwr & (sel1 | sel2);
    assign P_out    = pout_q;

    always_comb begin
        G_rd_data = 8'h00;
        if (G_rdwr && sel1) begin
            G_rd_data = {P_open_bus, 4'b0000, sr1_q[0]};
        end else if (G_rdwr && sel2) begin
            G_rd_data = {P_open_bus, 4'b0000, sr2_q[0]};
        end
    end

    // Loading follows the registered strobe, so the edge that clears it still loads the pads.
    always_comb begin
        strobe_d = strobe_q;
        pout_d   = pout_q;
        sr1_d    = sr1_q;
        sr2_d    = sr2_q;
        if (access_end && !G_rdwr && sel1) begin
            strobe_d = G_wr_data[0];
            pout_d   = G_wr_data[2:0];
        end
        if (strobe_q) begin
            sr1_d = P_pad1;
            sr2_d = P_pad2;
        end else if (access_end && G_rdwr) begin
            if (sel1) begin
                sr1_d = {1'b1, sr1_q[7:1]};
            end
            if (sel2) begin
                sr2_d = {1'b1, sr2_q[7:1]};
            end
        end
    end

    always_ff @(posedge G_clock or posedge G_reset) begin
        if (G_reset) begin
            phy2_q   <= 1'b0;
            strobe_q <= 1'b0;
            sr1_q    <= 8'hFF;
            sr2_q    <= 8'hFF;
            pout_q   <= 3'b000;
        end else begin
            phy2_q   <= G_phy2;
            strobe_q <= strobe_d;
            sr1_q    <= sr1_d;
            sr2_q    <= sr2_d;
            pout_q   <= pout_d;
        end
    end

endmodule

// File: tb/tb_q2a03_joypad.sv
// tb/tb_q2a03_joypad.sv - directed self-checking bench for q2a03_joypad
module tb_q2a03_joypad;

    logic        clk;
    logic        rst;
    logic        phy2;
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        rd_sel;
    logic [7:0]  pad1;
    logic [7:0]  pad2;
    logic [2:0]  p_out;

    int checks = 0;
    int errors = 0;

    q2a03_joypad dut (
        .G_clock   (clk),
        .G_reset   (rst),
        .G_phy2    (phy2),
        .G_addr    (addr),
        .G_rdwr    (rdwr),
        .G_wr_data (wr_data),
        .G_rd_data (rd_data),
        .G_rd_sel  (rd_sel),
        .P_pad1    (pad1),
        .P_pad2    (pad2),
        .P_out     (p_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; rdwr = 1'b0; wr_data = d; phy2 = 1'b1;
        repeat (2) @(negedge clk);
        phy2 = 1'b0;
        repeat (2) @(negedge clk);
        rdwr = 1'b1; addr = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic s);
        @(negedge clk);
        addr = a; rdwr = 1'b1; phy2 = 1'b1;
        repeat (2) @(negedge clk);
        d = rd_data; s = rd_sel;
        phy2 = 1'b0;
        repeat (2) @(negedge clk);
        addr = 16'h0000;
    endtask

    task automatic stalled_read(input logic [15:0] a, output logic [7:0] d, output logic s);
        @(negedge clk);
        addr = a; rdwr = 1'b1; phy2 = 1'b0;
        repeat (3) @(negedge clk);
        d = rd_data; s = rd_sel;
        addr = 16'h0000;
        @(negedge clk);
    endtask

    logic [7:0] d;
    logic       s;
    logic [9:0] seq;

    initial begin
        rst = 1'b1; phy2 = 1'b0; addr = 16'h0000; rdwr = 1'b1;
        wr_data = 8'h00; pad1 = 8'h00; pad2 = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("reset_pout", {5'b0, p_out}, 8'h00);
        chk("reset_idle_sel", {7'b0, rd_sel}, 8'h00);
        chk("reset_idle_data", rd_data, 8'h00);
        bus_read(16'h4016, d, s);
        chk("reset_read_4016", d, 8'h41);
        chk("reset_read_sel", {7'b0, s}, 8'h01);

        // A5 strobe cycle then 10 reads
        pad1 = 8'hA5;
        bus_write(16'h4016, 8'h01);
        bus_write(16'h4016, 8'h00);
        seq = 10'b11_1010_0101;
        for (int i = 0; i < 10; i++) begin
            bus_read(16'h4016, d, s);
            chk($sformatf("a5_read%0d", i), d, {7'b0100000, seq[i]});
        end

        // strobe held: reads track A bit, no shift
        bus_write(16'h4016, 8'h01);
        for (int i = 0; i < 4; i++) begin
            pad1 = (i % 2 == 0) ? 8'h00 : 8'h01;
            @(negedge clk);
            bus_read(16'h4016, d, s);
            chk($sformatf("strobe_track%0d", i), d, (i % 2 == 0) ? 8'h40 : 8'h41);
        end
        bus_write(16'h4016, 8'h00);

        // $4017 reads do not shift sr1
        pad1 = 8'hFF; pad2 = 8'h00;
        bus_write(16'h4016, 8'h01);
        bus_write(16'h4016, 8'h00);
        for (int i = 0; i < 3; i++) begin
            bus_read(16'h4017, d, s);
            chk($sformatf("p2_read%0d", i), d, 8'h40);
        end
        bus_read(16'h4016, d, s);
        chk("p1_unshifted", d, 8'h41);

        // expansion latch and ignored $4017 write
        pad1 = 8'h01;
        bus_write(16'h4016, 8'h07);
        chk("pout_111", {5'b0, p_out}, 8'h07);
        bus_read(16'h4016, d, s);
        chk("strobe_set_a1", d, 8'h41);
        pad1 = 8'h00;
        bus_write(16'h4017, 8'h00);
        chk("pout_kept", {5'b0, p_out}, 8'h07);
        bus_read(16'h4016, d, s);
        chk("strobe_kept_a0", d, 8'h40);
        bus_read(16'h4016, d, s);
        chk("strobe_kept_noshift", d, 8'h40);

        // reset after 3 shifted reads, mid-access
        pad1 = 8'h00; pad2 = 8'h00;
        bus_write(16'h4016, 8'h06);
        chk("pout_110", {5'b0, p_out}, 8'h06);
        for (int i = 0; i < 3; i++) begin
            bus_read(16'h4016, d, s);
            chk($sformatf("pre_reset_read%0d", i), d, 8'h40);
        end
        @(negedge clk);
        addr = 16'h4016; rdwr = 1'b0; wr_data = 8'h05; phy2 = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("reset_async_pout", {5'b0, p_out}, 8'h00);
        @(negedge clk);
        phy2 = 1'b0;
        @(negedge clk);
        rst = 1'b0; rdwr = 1'b1; addr = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset_pout_after", {5'b0, p_out}, 8'h00);
        bus_read(16'h4016, d, s);
        chk("reset_read_4016b", d, 8'h41);
        bus_read(16'h4017, d, s);
        chk("reset_read_4017", d, 8'h41);

        // other address, stalled bus, and address wiggle without phy2 fall
        pad1 = 8'hA5;
        bus_write(16'h4016, 8'h01);
        bus_write(16'h4016, 8'h00);
        bus_read(16'h4018, d, s);
        chk("other_sel", {7'b0, s}, 8'h00);
        chk("other_data", d, 8'h00);
        stalled_read(16'h4016, d, s);
        chk("stall_sel", {7'b0, s}, 8'h01);
        chk("stall_data", d, 8'h41);
        bus_read(16'h4016, d, s);
        chk("after_stall_bit0", d, 8'h41);
        bus_read(16'h4016, d, s);
        chk("after_stall_bit1", d, 8'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
